pair_triple_tester: RTL and testbench

PAIR_TRIPLE_TESTER -- requirements
Module: pair_triple_tester

---
 rtl/pair_triple_tester.sv | 102 ++++++++++
 tb/tb_pair_triple_tester.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pair_triple_tester.sv
// Sweeps all 8 input vectors into a pair/triple (majority) detector and scores its response.
// Each vector is held SETTLE cycles and sampled on the last; results hold in DONE until the next start.
module pair_triple_tester #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic       dut_in0,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] WLAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [2:0] ff_q, ff_d;
  logic       expected;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    expected = (idx_q[0] & idx_q[1]) | (idx_q[0] & idx_q[2]) | (idx_q[1] & idx_q[2]);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 3'd0;
          wcnt_d  = 4'd0;
          err_d   = 4'd0;
          fv_d    = 1'b0;
          ff_d    = 3'd0;
        end
      end
      DRIVE: begin
        if (wcnt_q != WLAST) begin
          wcnt_d = wcnt_q + 4'd1;
        end else begin
          wcnt_d = 4'd0;
          // At most 8 samples per sweep, so the 4-bit count cannot wrap
          if (dut_out != expected) begin
            err_d = err_q + 4'd1;
            if (!fv_q) begin
              fv_d = 1'b1;
              ff_d = idx_q;
            end
          end
          if (idx_q == 3'd7) state_d = DONE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      wcnt_q  <= 4'd0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      ff_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  // Outputs decode registered state only, so no combinational path from start or dut_out
  assign busy       = (state_q == DRIVE);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == 4'd0);
  assign dut_in0    = busy & idx_q[0];
  assign dut_in1    = busy & idx_q[1];
  assign dut_in2    = busy & idx_q[2];
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_pair_triple_tester.sv
// Runs two testers (SETTLE=1 and SETTLE=3) against a truth-table detector and a sweep-level model.
module tb_pair_triple_tester;

  localparam logic [7:0] TT_MAJ = 8'b1110_1000;
  localparam logic [7:0] TT_OR  = 8'b1111_1110;
  localparam logic [7:0] TT_S0  = 8'h00;
  localparam logic [7:0] TT_S1  = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tt = TT_MAJ;

  logic       busy_o[2], done_o[2], pass_o[2], fv_o[2];
  logic       d0[2], d1[2], d2[2], dout[2];
  logic [3:0] ec_o[2];
  logic [2:0] ff_o[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign dout[0] = tt[{d2[0], d1[0], d0[0]}];
  assign dout[1] = tt[{d2[1], d1[1], d0[1]}];

  pair_triple_tester #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .dut_out(dout[0]),
    .dut_in0(d0[0]), .dut_in1(d1[0]), .dut_in2(d2[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_count(ec_o[0]), .fail_valid(fv_o[0]), .first_fail(ff_o[0])
  );

  pair_triple_tester #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .dut_out(dout[1]),
    .dut_in0(d0[1]), .dut_in1(d1[1]), .dut_in2(d2[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_count(ec_o[1]), .fail_valid(fv_o[1]), .first_fail(ff_o[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit maj(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  // Model: phase 0=idle 1=sweeping 2=results; k counts cycles spent sweeping
  int sv[2] = '{1, 3};
  int ph[2] = '{0, 0};
  int k[2] = '{0, 0};
  int errs[2] = '{0, 0};
  int fv[2] = '{0, 0};
  int ff[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] = 0; k[i] = 0; errs[i] = 0; fv[i] = 0; ff[i] = 0;
      end else if (ph[i] != 1) begin
        if (start) begin
          ph[i] = 1; k[i] = 0; errs[i] = 0; fv[i] = 0; ff[i] = 0;
        end
      end else begin
        int vec;
        vec = k[i] / sv[i];
        if (k[i] % sv[i] == sv[i] - 1) begin
          if (tt[vec] != maj(3'(vec))) begin
            errs[i]++;
            if (fv[i] == 0) begin
              fv[i] = 1;
              ff[i] = vec;
            end
          end
        end
        k[i]++;
        if (k[i] == 8 * sv[i]) ph[i] = 2;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ev;
      ev = (ph[i] == 1) ? k[i] / sv[i] : 0;
      chk($sformatf("u%0d_busy", i), busy_o[i], ph[i] == 1);
      chk($sformatf("u%0d_done", i), done_o[i], ph[i] == 2);
      chk($sformatf("u%0d_pass", i), pass_o[i], (ph[i] == 2) && (errs[i] == 0));
      chk($sformatf("u%0d_dut_in", i), {d2[i], d1[i], d0[i]}, ev);
      chk($sformatf("u%0d_err_count", i), ec_o[i], errs[i]);
      chk($sformatf("u%0d_fail_valid", i), fv_o[i], fv[i]);
      chk($sformatf("u%0d_first_fail", i), ff_o[i], ff[i]);
      if (busy_o[i] && done_o[i]) chk($sformatf("u%0d_busy_done_excl", i), 1, 0);
    end
  end

  task automatic kick(input logic [7:0] t);
    @(negedge clk);
    tt = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c1, output int c3);
    c1 = 0;
    c3 = 0;
    for (int n = 0; n < 100; n++) begin
      if (busy_o[0]) c1++;
      if (busy_o[1]) c3++;
      if (done_o[0] && done_o[1]) break;
      @(negedge clk);
    end
    chk("sweep_completes", done_o[0] && done_o[1], 1);
  endtask

  int c1, c3;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy_o[0], 0);
    chk("reset_done", done_o[1], 0);
    rst = 1'b0;

    kick(TT_MAJ);
    wait_done(c1, c3);
    chk("maj_busy_cycles_s1", c1, 8);
    chk("maj_busy_cycles_s3", c3, 24);
    chk("maj_pass", pass_o[0], 1);
    chk("maj_err", ec_o[0], 0);
    chk("maj_fv", fv_o[1], 0);
    chk("model_maj_err", errs[0], 0);

    kick(TT_S0);
    wait_done(c1, c3);
    chk("s0_err", ec_o[0], 4);
    chk("s0_first", ff_o[0], 3);
    chk("s0_fv", fv_o[0], 1);
    chk("s0_pass", pass_o[0], 0);
    chk("model_s0_err", errs[1], 4);

    kick(TT_S1);
    wait_done(c1, c3);
    chk("s1_err", ec_o[0], 4);
    chk("s1_first", ff_o[0], 0);
    chk("s1_pass", pass_o[1], 0);

    kick(TT_OR);
    wait_done(c1, c3);
    chk("or_busy_cycles_s3", c3, 24);
    chk("or_err_s3", ec_o[1], 3);
    chk("or_first_s3", ff_o[1], 1);
    chk("model_or_first", ff[1], 1);

    // Reset mid-sweep once the SETTLE=1 tester reaches vector 4
    kick(TT_MAJ);
    repeat (4) @(negedge clk);
    chk("mid_idx4", {d2[0], d1[0], d0[0]}, 4);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("mid_rst_busy", busy_o[0], 0);
    chk("mid_rst_err", ec_o[0], 0);
    kick(TT_S0);
    wait_done(c1, c3);
    chk("after_rst_cycles", c1, 8);
    chk("after_rst_err", ec_o[0], 4);

    // start during the sweep is ignored
    kick(TT_MAJ);
    repeat (2) @(negedge clk);
    chk("ign_idx2", {d2[0], d1[0], d0[0]}, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c1, c3);
    chk("ign_pass", pass_o[0], 1);

    kick(TT_S1);
    chk("restart_cleared", pass_o[0], 0);
    wait_done(c1, c3);
    chk("restart_err", ec_o[1], 4);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom % 6) == 0;
      rst   = ($urandom % 97) == 0;
      if ($urandom % 20 == 0) tt = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
